// File: rtl/phased_pwm_array.sv
// phased_pwm_array: multi-channel phased carrier generator with
// double-buffered offsets and master/follower period alignment.
module phased_pwm_array #(
    parameter int NUM_CH = 4,
    parameter int PERIOD = 1250,
    parameter int CNT_W  = $clog2(PERIOD),
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic              commit,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_mode,
    input  logic              sync_in,
    output logic              sync_out,
    output logic [NUM_CH-1:0] trans,
    output logic              wr_err,
    output logic              commit_pending
);
    localparam logic [CNT_W:0]   PER_X  = (CNT_W+1)'(PERIOD);
    localparam logic [CNT_W:0]   HALF_X = (CNT_W+1)'(PERIOD / 2);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);
    localparam logic [CH_W:0]    NCH_X  = (CH_W+1)'(NUM_CH);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] phase_sh   [NUM_CH];
    logic [CNT_W-1:0] cal_sh     [NUM_CH];
    logic [CNT_W-1:0] active_off [NUM_CH];
    logic [CNT_W-1:0] off_next   [NUM_CH];
    logic [CNT_W:0]   sum_w      [NUM_CH];
    logic [CNT_W:0]   diff_w     [NUM_CH];
    logic [NUM_CH-1:0] trans_next;

    logic sync_s1;
    logic sync_s2;
    logic sync_s3;
    logic resync;
    logic boundary;
    logic wr_ok;
    logic apply;

    // sync_s3 is the edge-detect flop behind the two-stage synchroniser
    assign resync   = sync_mode && sync_s2 && !sync_s3;
    assign boundary = resync || (cnt == LAST);
    assign wr_ok    = wr_en
                   && ({1'b0, wr_ch} < NCH_X)
                   && ({1'b0, wr_data} < PER_X);
    assign apply    = boundary && (commit_pending || commit);

    always_comb begin
        trans_next = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            sum_w[ch] = {1'b0, phase_sh[ch]} + {1'b0, cal_sh[ch]};
            if (sum_w[ch] >= PER_X)
                off_next[ch] = CNT_W'(sum_w[ch] - PER_X);
            else
                off_next[ch] = sum_w[ch][CNT_W-1:0];
            // phase distance of cnt past this channel's offset, mod PERIOD
            if (cnt >= active_off[ch])
                diff_w[ch] = {1'b0, cnt} - {1'b0, active_off[ch]};
            else
                diff_w[ch] = {1'b0, cnt} + PER_X - {1'b0, active_off[ch]};
            trans_next[ch] = ch_en[ch] && (diff_w[ch] < HALF_X);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt            <= '0;
            sync_s1        <= 1'b0;
            sync_s2        <= 1'b0;
            sync_s3        <= 1'b0;
            sync_out       <= 1'b0;
            trans          <= '0;
            wr_err         <= 1'b0;
            commit_pending <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                phase_sh[ch]   <= '0;
                cal_sh[ch]     <= '0;
                active_off[ch] <= '0;
            end
        end else begin
            sync_s1  <= sync_in;
            sync_s2  <= sync_s1;
            sync_s3  <= sync_s2;
            cnt      <= boundary ? '0 : cnt + CNT_W'(1);
            sync_out <= boundary;
            trans    <= trans_next;
            wr_err   <= wr_en && !wr_ok;
            if (wr_ok) begin
                if (wr_sel)
                    cal_sh[wr_ch] <= wr_data;
                else
                    phase_sh[wr_ch] <= wr_data;
            end
            if (apply) begin
                for (int ch = 0; ch < NUM_CH; ch++)
                    active_off[ch] <= off_next[ch];
            end
            commit_pending <= boundary ? 1'b0 : (commit_pending || commit);
        end
    end
endmodule

// File: tb/tb_phased_pwm_array.sv
// tb_phased_pwm_array: directed bench for phased_pwm_array with a
// cycle-level expectation of trans/sync_out/wr_err/commit_pending.
module tb_phased_pwm_array;
    localparam int P = 1250;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [10:0] wr_data = '0;
    logic        commit = 1'b0;
    logic [3:0]  ch_en = '0;
    logic        sync_mode = 1'b0;
    logic        sync_in = 1'b0;
    logic        sync_out;
    logic [3:0]  trans;
    logic        wr_err;
    logic        commit_pending;

    int n_cmp = 0;
    int n_bad = 0;
    int ec = 0;
    int eoff [4] = '{0, 0, 0, 0};
    int enext [4] = '{0, 0, 0, 0};
    bit pend = 1'b0;

    phased_pwm_array dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_ch(wr_ch), .wr_data(wr_data),
        .commit(commit), .ch_en(ch_en),
        .sync_mode(sync_mode), .sync_in(sync_in),
        .sync_out(sync_out), .trans(trans),
        .wr_err(wr_err), .commit_pending(commit_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s at cnt=%0d: observed %0h expected %0h",
                   tag, ec, obs, exp);
        end
    endtask

    // One clock edge; rs marks an edge where a follower resync is expected.
    task automatic tick(input bit rs);
        logic [3:0] et;
        bit es;
        bit ew;
        bit bnd;
        int nc;
        int d;
        et = '0;
        for (int ch = 0; ch < 4; ch++) begin
            d = (ec - eoff[ch] + P) % P;
            et[ch] = ch_en[ch] && (d < P / 2);
        end
        if (!rst_n) begin
            nc = 0;
            et = '0;
            es = 1'b0;
            ew = 1'b0;
            pend = 1'b0;
            for (int ch = 0; ch < 4; ch++) eoff[ch] = 0;
        end else begin
            bnd = rs || (ec == P - 1);
            nc = bnd ? 0 : ec + 1;
            es = bnd;
            ew = wr_en && (int'(wr_data) >= P);
            if (bnd) begin
                if (pend || commit)
                    for (int ch = 0; ch < 4; ch++) eoff[ch] = enext[ch];
                pend = 1'b0;
            end else if (commit) begin
                pend = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        ec = nc;
        chk("tick_trans", 32'(trans), 32'(et));
        chk("tick_sync_out", 32'(sync_out), 32'(es));
        chk("tick_wr_err", 32'(wr_err), 32'(ew));
        chk("tick_pending", 32'(commit_pending), 32'(pend));
    endtask

    task automatic run_to(input int c);
        int k;
        k = 0;
        while (ec != c && k < 2 * P) begin
            tick(1'b0);
            k++;
        end
    endtask

    task automatic wr(input bit sel, input int ch, input int data);
        wr_en = 1'b1;
        wr_sel = sel;
        wr_ch = 2'(ch);
        wr_data = 11'(data);
        tick(1'b0);
        wr_en = 1'b0;
    endtask

    task automatic cmt(input int o0, input int o1, input int o2,
                       input int o3);
        enext = '{o0, o1, o2, o3};
        commit = 1'b1;
        tick(1'b0);
        commit = 1'b0;
    endtask

    initial begin
        tick(1'b0);
        tick(1'b0);
        chk("rst_trans", 32'(trans), 32'h0);
        chk("rst_sync_out", 32'(sync_out), 32'h0);
        chk("rst_pending", 32'(commit_pending), 32'h0);
        chk("rst_wr_err", 32'(wr_err), 32'h0);

        // free-running master carrier, all offsets zero
        rst_n = 1'b1;
        ch_en = 4'hF;
        tick(1'b0);
        chk("t1_first_rise", 32'(trans), 32'hF);
        run_to(625);
        chk("t1_high_end", 32'(trans), 32'hF);
        tick(1'b0);
        chk("t1_fall", 32'(trans), 32'h0);
        run_to(1249);
        chk("t1_no_sync", 32'(sync_out), 32'h0);
        tick(1'b0);
        chk("t1_sync", 32'(sync_out), 32'h1);
        tick(1'b0);
        chk("t1_sync_drop", 32'(sync_out), 32'h0);
        chk("t1_rise2", 32'(trans), 32'hF);
        run_to(0);
        chk("t1_sync2", 32'(sync_out), 32'h1);

        // rejected writes leave every shadow at zero
        run_to(50);
        wr(1'b0, 1, 1250);
        chk("t4_err_data", 32'(wr_err), 32'h1);
        tick(1'b0);
        chk("t4_err_clear", 32'(wr_err), 32'h0);
        wr(1'b1, 2, 2047);
        chk("t4_err_max", 32'(wr_err), 32'h1);
        tick(1'b0);
        cmt(0, 0, 0, 0);
        chk("t4_pending", 32'(commit_pending), 32'h1);
        run_to(0);
        chk("t4_applied", 32'(commit_pending), 32'h0);
        run_to(626);
        chk("t4_offsets_zero", 32'(trans), 32'h0);

        // ch1 phase 625 -> complement of ch0
        run_to(0);
        run_to(99);
        wr(1'b0, 1, 625);
        cmt(0, 625, 0, 0);
        chk("t2_pending", 32'(commit_pending), 32'h1);
        run_to(1249);
        chk("t2_pending_hold", 32'(commit_pending), 32'h1);
        tick(1'b0);
        chk("t2_cleared", 32'(commit_pending), 32'h0);
        run_to(10);
        chk("t2_early", 32'(trans), 32'hD);
        run_to(700);
        chk("t2_late", 32'(trans), 32'h2);

        // ch2 phase 1000 + cal 500 wraps to 250
        wr(1'b0, 2, 1000);
        wr(1'b1, 2, 500);
        cmt(0, 625, 250, 0);
        run_to(0);
        run_to(250);
        chk("t3_pre_rise", 32'(trans), 32'h9);
        tick(1'b0);
        chk("t3_rise", 32'(trans), 32'hD);
        run_to(875);
        chk("t3_pre_fall", 32'(trans), 32'h6);
        tick(1'b0);
        chk("t3_fall", 32'(trans), 32'h2);

        // ch2 offset 1249
        wr(1'b1, 2, 0);
        wr(1'b0, 2, 1249);
        cmt(0, 625, 1249, 0);
        run_to(0);
        run_to(1249);
        chk("t3b_pre_rise", 32'(trans), 32'h2);
        tick(1'b0);
        chk("t3b_rise", 32'(trans), 32'h6);

        // immediate channel disable
        ch_en = 4'b1011;
        tick(1'b0);
        chk("en_stop", 32'(trans), 32'h9);
        ch_en = 4'hF;

        // follower resync with a pending commit
        sync_mode = 1'b1;
        wr(1'b0, 3, 100);
        run_to(300);
        cmt(0, 625, 1249, 100);
        run_to(400);
        sync_in = 1'b1;
        tick(1'b0);
        tick(1'b0);
        chk("t5_not_yet", 32'(sync_out), 32'h0);
        chk("t5_still_pend", 32'(commit_pending), 32'h1);
        tick(1'b1);
        chk("t5_resync", 32'(sync_out), 32'h1);
        chk("t5_commit_done", 32'(commit_pending), 32'h0);
        tick(1'b0);
        chk("t5_new_offs", 32'(trans), 32'h5);
        run_to(50);
        sync_in = 1'b0;
        run_to(60);

        // master ignores sync_in
        sync_mode = 1'b0;
        run_to(400);
        sync_in = 1'b1;
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        chk("t5_master_sync", 32'(sync_out), 32'h0);
        chk("t5_master_trans", 32'(trans), 32'hD);
        run_to(420);
        sync_in = 1'b0;

        // reset with a pending commit
        run_to(599);
        wr(1'b0, 0, 300);
        cmt(300, 625, 1249, 100);
        run_to(700);
        chk("t6_pend_before", 32'(commit_pending), 32'h1);
        rst_n = 1'b0;
        tick(1'b0);
        chk("t6_pending", 32'(commit_pending), 32'h0);
        chk("t6_trans", 32'(trans), 32'h0);
        chk("t6_sync_out", 32'(sync_out), 32'h0);
        rst_n = 1'b1;
        tick(1'b0);
        chk("t6_restart", 32'(trans), 32'hF);
        run_to(626);
        chk("t6_zero_offs", 32'(trans), 32'h0);
        cmt(0, 0, 0, 0);
        run_to(0);
        run_to(1);
        chk("t6_shadows_clear", 32'(trans), 32'hF);
        run_to(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
